// File: rtl/stage_evaluator_if.sv
// Control and ROM bus between the window evaluator and the cascade sequencer.
// The sequencer/ROM side uses master; the evaluator uses slave.
interface stage_evaluator_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int ROM_WIDTH  = 16,
    parameter int CNT_WIDTH  = 8,
    parameter int ACC_WIDTH  = 24
) ();
    logic                  i_start;
    logic [ADDR_WIDTH-1:0] i_stage_base_addr;
    logic [CNT_WIDTH-1:0]  i_num_classifiers;
    logic [ACC_WIDTH-1:0]  i_stage_threshold;
    logic [ADDR_WIDTH-1:0] o_rom_address;
    logic [ROM_WIDTH-1:0]  i_rom_q;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_is_pass;
    logic [ACC_WIDTH-1:0]  o_stage_sum;

    modport master (
        output i_start, i_stage_base_addr, i_num_classifiers,
        output i_stage_threshold, i_rom_q,
        input  o_rom_address, o_busy, o_done, o_is_pass, o_stage_sum
    );

    modport slave (
        input  i_start, i_stage_base_addr, i_num_classifiers,
        input  i_stage_threshold, i_rom_q,
        output o_rom_address, o_busy, o_done, o_is_pass, o_stage_sum
    );
endinterface

// File: rtl/stage_evaluator.sv
// Evaluates one Haar cascade stage: streams classifier parameters from ROM,
// computes weighted rectangle features and accumulates votes into a stage sum.
module stage_evaluator #(
    parameter int ADDR_WIDTH               = 10,
    parameter int ROM_WIDTH                = 16,
    parameter int DATA_WIDTH_12            = 12,
    parameter int INTEGRAL_WIDTH           = 24,
    parameter int INTEGRAL_HEIGHT          = 24,
    parameter int INDEX_WIDTH              = 10,
    parameter int NUM_RECT                 = 3,
    parameter int NUM_PARAM_PER_CLASSIFIER = 5*NUM_RECT+3,
    parameter int CNT_WIDTH                = 8,
    parameter int ACC_WIDTH                = 24
) (
    input  logic clk_fpga,
    input  logic reset_fpga,
    input  logic [INTEGRAL_WIDTH*INTEGRAL_HEIGHT*DATA_WIDTH_12-1:0] i_integral_image,
    stage_evaluator_if.slave bus
);
    localparam int P    = NUM_PARAM_PER_CLASSIFIER;
    localparam int NPIX = INTEGRAL_WIDTH*INTEGRAL_HEIGHT;
    localparam int RW   = DATA_WIDTH_12+2;
    localparam int SW   = $clog2(P+1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EVAL  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                   r_state;
    logic [SW-1:0]                r_step;
    logic [CNT_WIDTH-1:0]         r_cls;
    logic [CNT_WIDTH-1:0]         r_num;
    logic [ADDR_WIDTH-1:0]        r_addr;
    logic signed [ACC_WIDTH-1:0]  r_thr;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic signed [ACC_WIDTH-1:0]  r_sum;
    logic                         r_busy;
    logic                         r_done;
    logic                         r_pass;
    logic [ROM_WIDTH-1:0]         r_param [P];

    logic signed [23:0]           w_feature;
    logic signed [RW-1:0]         w_rect;
    logic signed [23:0]           w_rect_x;
    logic signed [23:0]           w_weight_x;
    logic signed [23:0]           w_node;
    logic signed [ACC_WIDTH-1:0]  w_left;
    logic signed [ACC_WIDTH-1:0]  w_right;
    logic signed [ACC_WIDTH-1:0]  w_vote;

    // Out-of-window corner indices read as zero.
    function automatic logic signed [RW-1:0] pix(input logic [INDEX_WIDTH-1:0] idx);
        pix = '0;
        if (int'(idx) < NPIX)
            pix = RW'(i_integral_image[int'(idx)*DATA_WIDTH_12 +: DATA_WIDTH_12]);
    endfunction

    always_comb begin
        w_feature  = '0;
        w_rect     = '0;
        w_rect_x   = '0;
        w_weight_x = '0;
        for (int r = 0; r < NUM_RECT; r++) begin
            w_rect = pix(r_param[5*r][INDEX_WIDTH-1:0])
                   - pix(r_param[5*r+1][INDEX_WIDTH-1:0])
                   - pix(r_param[5*r+2][INDEX_WIDTH-1:0])
                   + pix(r_param[5*r+3][INDEX_WIDTH-1:0]);
            w_rect_x   = 24'(w_rect);
            w_weight_x = 24'($signed(r_param[5*r+4][7:0]));
            w_feature  = w_feature + w_weight_x * w_rect_x;
        end
    end

    assign w_node  = 24'($signed(r_param[5*NUM_RECT]));
    assign w_left  = ACC_WIDTH'($signed(r_param[5*NUM_RECT+1]));
    assign w_right = ACC_WIDTH'($signed(r_param[5*NUM_RECT+2]));
    assign w_vote  = (w_feature < w_node) ? w_left : w_right;

    always_ff @(posedge clk_fpga) begin
        if (reset_fpga) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_cls   <= '0;
            r_num   <= '0;
            r_addr  <= '0;
            r_thr   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            for (int i = 0; i < P; i++)
                r_param[i] <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_addr  <= bus.i_stage_base_addr;
                        r_num   <= bus.i_num_classifiers;
                        r_thr   <= $signed(bus.i_stage_threshold);
                        r_acc   <= '0;
                        r_cls   <= '0;
                        r_step  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= (bus.i_num_classifiers == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    // ROM is one cycle behind the address, so step k fills word k-1.
                    if (r_step != '0)
                        r_param[r_step - SW'(1)] <= bus.i_rom_q;
                    if (r_step == SW'(P)) begin
                        r_step  <= '0;
                        r_state <= S_EVAL;
                    end else begin
                        r_step <= r_step + SW'(1);
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                    end
                end
                S_EVAL: begin
                    r_acc <= r_acc + w_vote;
                    if (r_cls == r_num - CNT_WIDTH'(1)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cls   <= r_cls + CNT_WIDTH'(1);
                        r_state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_sum   <= r_acc;
                    r_pass  <= (r_acc >= r_thr);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_rom_address = r_addr;
    assign bus.o_busy        = r_busy;
    assign bus.o_done        = r_done;
    assign bus.o_is_pass     = r_pass;
    assign bus.o_stage_sum   = r_sum;
endmodule

// File: tb/tb_stage_evaluator.sv
// Directed bench for stage_evaluator with a synchronous ROM model.
// Each task drives one scenario and checks its own results.
module tb_stage_evaluator;
    localparam int P  = 18;
    localparam int IW = 24*24*12;

    logic            clk_fpga;
    logic            reset_fpga;
    logic [IW-1:0]   img;
    logic [15:0]     rom [1024];
    int              checks;
    int              errors;

    stage_evaluator_if bus ();

    stage_evaluator dut (
        .clk_fpga         (clk_fpga),
        .reset_fpga       (reset_fpga),
        .i_integral_image (img),
        .bus              (bus)
    );

    initial clk_fpga = 1'b0;
    always #5 clk_fpga = ~clk_fpga;

    always @(posedge clk_fpga)
        bus.i_rom_q <= rom[bus.o_rom_address];

    task automatic put_cls(input int b, input int a0, input int b0,
                           input int c0, input int d0, input int w0,
                           input int thr, input int l, input int r);
        for (int i = 0; i < P; i++)
            rom[b+i] = 16'd0;
        rom[b+0]  = 16'(a0);
        rom[b+1]  = 16'(b0);
        rom[b+2]  = 16'(c0);
        rom[b+3]  = 16'(d0);
        rom[b+4]  = 16'(w0);
        rom[b+15] = 16'(thr);
        rom[b+16] = 16'(l);
        rom[b+17] = 16'(r);
    endtask

    task automatic start_stage(input int base, input int n, input int thr);
        bus.i_stage_base_addr = 10'(base);
        bus.i_num_classifiers = 8'(n);
        bus.i_stage_threshold = 24'(thr);
        bus.i_start = 1'b1;
        @(posedge clk_fpga);
        #1;
        bus.i_start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input bit spam, output int lat);
        lat = -1;
        for (int c = 1; c <= limit; c++) begin
            @(posedge clk_fpga);
            #1;
            if (bus.o_done) begin
                lat = c;
                break;
            end
            if (spam) begin
                bus.i_start = (c % 5 == 2);
                bus.i_num_classifiers = 8'd0;
                bus.i_stage_threshold = 24'hFFFF00;
            end
        end
        bus.i_start = 1'b0;
    endtask

    task automatic test_reset;
        reset_fpga = 1'b1;
        repeat (2) @(posedge clk_fpga);
        #1;
        checks++;
        if (bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", bus.o_busy);
        end
        checks++;
        if (bus.o_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got %b want 0", bus.o_done);
        end
        checks++;
        if (bus.o_is_pass !== 1'b0) begin
            errors++;
            $display("FAIL reset_pass got %b want 0", bus.o_is_pass);
        end
        checks++;
        if (bus.o_stage_sum !== 24'd0) begin
            errors++;
            $display("FAIL reset_sum got %0d want 0", bus.o_stage_sum);
        end
        checks++;
        if (bus.o_rom_address !== 10'd0) begin
            errors++;
            $display("FAIL reset_addr got %0d want 0", bus.o_rom_address);
        end
        reset_fpga = 1'b0;
    endtask

    task automatic test_single(input int node, input int esum, input bit epass);
        int lat;
        put_cls(0, 0, 1, 2, 3, -1, node, 7, -3);
        start_stage(0, 1, 5);
        checks++;
        if (bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy node %0d got %b want 1", node, bus.o_busy);
        end
        wait_done(100, 1'b0, lat);
        checks++;
        if (lat !== 21) begin
            errors++;
            $display("FAIL single_lat node %0d got %0d want 21", node, lat);
        end
        checks++;
        if ($signed(bus.o_stage_sum) !== 24'(esum)) begin
            errors++;
            $display("FAIL single_sum node %0d got %0d want %0d",
                     node, $signed(bus.o_stage_sum), esum);
        end
        checks++;
        if (bus.o_is_pass !== epass) begin
            errors++;
            $display("FAIL single_pass node %0d got %b want %b", node, bus.o_is_pass, epass);
        end
        checks++;
        if (bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_drop got %b want 0", bus.o_busy);
        end
        @(posedge clk_fpga);
        #1;
        checks++;
        if (bus.o_done !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse got %b want 0", bus.o_done);
        end
    endtask

    task automatic test_zero(input int thr, input bit epass);
        int lat;
        start_stage(0, 0, thr);
        wait_done(10, 1'b0, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL zero_lat thr %0d got %0d want 1", thr, lat);
        end
        checks++;
        if (bus.o_stage_sum !== 24'd0) begin
            errors++;
            $display("FAIL zero_sum got %0d want 0", bus.o_stage_sum);
        end
        checks++;
        if (bus.o_is_pass !== epass) begin
            errors++;
            $display("FAIL zero_pass thr %0d got %b want %b", thr, bus.o_is_pass, epass);
        end
    endtask

    task automatic test_multi;
        int lat;
        int votes [4];
        votes = '{5, 5, -2, 1};
        for (int i = 0; i < 4; i++)
            put_cls(100 + i*P, 0, 0, 0, 0, 0, 1, votes[i], -50);
        start_stage(100, 4, 9);
        wait_done(200, 1'b1, lat);
        checks++;
        if (lat !== 81) begin
            errors++;
            $display("FAIL multi_lat got %0d want 81", lat);
        end
        checks++;
        if ($signed(bus.o_stage_sum) !== 24'sd9) begin
            errors++;
            $display("FAIL multi_sum got %0d want 9", $signed(bus.o_stage_sum));
        end
        checks++;
        if (bus.o_is_pass !== 1'b1) begin
            errors++;
            $display("FAIL multi_pass got %b want 1", bus.o_is_pass);
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        seen = 1'b0;
        put_cls(0, 0, 1, 2, 3, -1, -50, 7, -3);
        start_stage(0, 1, 5);
        repeat (9) @(posedge clk_fpga);
        #1;
        reset_fpga = 1'b1;
        @(posedge clk_fpga);
        #1;
        checks++;
        if (bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy got %b want 0", bus.o_busy);
        end
        reset_fpga = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk_fpga);
            #1;
            if (bus.o_done)
                seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_done got %b want 0", seen);
        end
        test_single(-50, -3, 1'b0);
    endtask

    task automatic test_oor(input int corner, input int node, input int esum, input bit epass);
        int lat;
        put_cls(200, corner, 1, 2, 3, 1, node, 11, -4);
        start_stage(200, 1, 0);
        wait_done(100, 1'b0, lat);
        checks++;
        if (lat !== 21) begin
            errors++;
            $display("FAIL oor_lat corner %0d got %0d want 21", corner, lat);
        end
        checks++;
        if ($signed(bus.o_stage_sum) !== 24'(esum)) begin
            errors++;
            $display("FAIL oor_sum corner %0d got %0d want %0d",
                     corner, $signed(bus.o_stage_sum), esum);
        end
        checks++;
        if (bus.o_is_pass !== epass) begin
            errors++;
            $display("FAIL oor_pass corner %0d got %b want %b", corner, bus.o_is_pass, epass);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        put_cls(300, 0, 1, 2, 3, -1, -30, 7, -3);
        put_cls(400, 576, 1, 2, 3, 1, -60, 11, -4);
        start_stage(300, 1, 5);
        wait_done(100, 1'b0, lat);
        checks++;
        if ($signed(bus.o_stage_sum) !== 24'sd7) begin
            errors++;
            $display("FAIL b2b_first_sum got %0d want 7", $signed(bus.o_stage_sum));
        end
        start_stage(400, 1, -4);
        checks++;
        if (bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_busy got %b want 1", bus.o_busy);
        end
        wait_done(100, 1'b0, lat);
        checks++;
        if (lat !== 21) begin
            errors++;
            $display("FAIL b2b_lat got %0d want 21", lat);
        end
        checks++;
        if ($signed(bus.o_stage_sum) !== -24'sd4) begin
            errors++;
            $display("FAIL b2b_sum got %0d want -4", $signed(bus.o_stage_sum));
        end
        checks++;
        if (bus.o_is_pass !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pass got %b want 1", bus.o_is_pass);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_fpga = 1'b1;
        bus.i_start = 1'b0;
        bus.i_stage_base_addr = '0;
        bus.i_num_classifiers = '0;
        bus.i_stage_threshold = '0;
        for (int i = 0; i < 1024; i++)
            rom[i] = 16'd0;
        img = '0;
        img[0*12 +: 12] = 12'd100;
        img[1*12 +: 12] = 12'd40;
        img[2*12 +: 12] = 12'd30;
        img[3*12 +: 12] = 12'd10;
        img[575*12 +: 12] = 12'd999;

        test_reset();
        test_single(-50, -3, 1'b0);
        test_single(-40, -3, 1'b0);
        test_single(-30, 7, 1'b1);
        test_zero(0, 1'b1);
        test_zero(1, 1'b0);
        test_multi();
        test_reset_mid();
        test_oor(600, -59, 11, 1'b1);
        test_oor(576, -60, -4, 1'b0);
        test_back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stage_evaluator.md
Name: stage_evaluator

Overview:
Parametrised successor to the single-stage FIFO classifier. It evaluates one complete Haar cascade stage over a latched integral-image window. For each classifier it streams parameters from an external synchronous ROM, computes the weighted rectangle feature, selects the left or right vote, and accumulates the stage sum. It then reports pass/fail against the stage threshold, and sits between the window buffer and the cascade sequencer.

Parameters:
ADDR_WIDTH, 10, ROM address width
ROM_WIDTH, 16, ROM word width; all parameters are signed or unsigned in this width
DATA_WIDTH_12, 12, integral pixel width (unsigned)
INTEGRAL_WIDTH, 24, window width in pixels
INTEGRAL_HEIGHT, 24, window height in pixels
INDEX_WIDTH, 10, rectangle-corner index width (low bits of the ROM word)
NUM_RECT, 3, rectangles per classifier (2 or 3)
NUM_PARAM_PER_CLASSIFIER, 5*NUM_RECT+3, ROM words per classifier
CNT_WIDTH, 8, classifier-count width
ACC_WIDTH, 24, signed stage-sum width

Ports:
clk_fpga  in  1  clock
reset_fpga  in  1  synchronous, active-high reset
i_start  in  1  start a stage evaluation; honoured only in IDLE
i_stage_base_addr  in  ADDR_WIDTH  ROM address of the stage's first classifier word
i_num_classifiers  in  CNT_WIDTH  classifiers in the stage
i_stage_threshold  in  ACC_WIDTH  signed stage threshold
i_integral_image  in  INTEGRAL_WIDTH*INTEGRAL_HEIGHT*DATA_WIDTH_12  flat window; element k occupies bits [k*12+:12]; held stable while o_busy
o_rom_address  out  ADDR_WIDTH  ROM read address
i_rom_q  in  ROM_WIDTH  ROM data, valid 1 cycle after address
o_busy  out  1  evaluation in progress
o_done  out  1  single-cycle completion pulse
o_is_pass  out  1  stage result, valid from the o_done pulse until the next start
o_stage_sum  out  ACC_WIDTH  final signed stage sum

Behaviour:
- Clock is clk_fpga; reset is reset_fpga, synchronous and active-high.
- Reset (including mid-evaluation) forces IDLE. All outputs go to 0; the accumulator, counters and parameter registers clear. No o_done is issued for an aborted run.
- In IDLE, i_start=1 latches base, count and threshold, clears the accumulator, sets o_busy and enters FETCH. i_start while busy is ignored.
- FETCH, per classifier, lasts NUM_PARAM_PER_CLASSIFIER+1 cycles (P+1):
  - o_rom_address = base + classifier*P + k on step k=0..P-1.
  - On steps 1..P, i_rom_q is captured into parameter register k-1.
- ROM word order, per rectangle r:
  - A index, B index, C index, D index, weight (signed, low 8 bits);
  - after the rectangles: node threshold (signed), left vote (signed), right vote (signed).
- EVAL (1 cycle):
  - rect_r = A - B - C + D, computed signed in DATA_WIDTH_12+2 bits.
  - feature = sum of weight_r*rect_r, computed signed in 24 bits.
  - vote = left if feature < node threshold, else right (equality selects right).
  - acc += sign-extended vote; the addition wraps in two's complement.
- After EVAL, go back to FETCH for the next classifier. After the last one, go to DONE.
- DONE (1 cycle):
  - o_done=1; o_stage_sum = acc; o_is_pass = (acc >= threshold), compared signed.
  - o_busy drops with o_done; the state returns to IDLE.
- Latency: o_done is high exactly N*(P+2)+1 cycles after the start edge. With N=0 it is 1 cycle later, sum=0, and pass iff threshold <= 0.
- Any corner index >= INTEGRAL_WIDTH*INTEGRAL_HEIGHT reads as 0.
- A weight of 0 contributes 0. With NUM_RECT=2, P=13.
- i_start can be accepted in the IDLE cycle immediately after DONE, giving back-to-back stages with no extra gap.

Test Plan:
- Single classifier, NUM_RECT=3, pixel at idx 0..3 = 100,40,30,10, rect1 (0,1,2,3) weight -1, rects 2/3 weight 0, node threshold -50, left 7, right -3, stage threshold 5 -> feature -40, vote -3, o_stage_sum=-3, o_is_pass=0, o_done at cycle 21.
- Same, node threshold -40 (equality) -> right vote -3; with node threshold -30 -> left 7, sum 7, pass=1.
- i_num_classifiers=0, threshold 0 -> o_done 1 cycle after start, sum 0, pass=1; with threshold 1 -> pass=0.
- 4 classifiers with votes +5,+5,-2,+1, threshold 9 -> sum 9, pass=1, o_done at cycle 81; i_start pulses while busy produce no effect.
- reset_fpga asserted at cycle 10 of a run -> next cycle o_busy=0, o_done never pulses; a new start gives a correct full result.
- Corner index 600 (out of range) with weight 1 -> that corner is treated as 0; rect value equals the in-range corners only.
